// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment scanner.
// Holds a double-buffered hex display word that changes only at frame
// boundaries, scans one digit per divider period, and applies PWM dimming
// and optional leading-zero blanking. All outputs are registered.
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 8,
    parameter int COUNT_PERIOD = 100000
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [4*NUM_DIGITS-1:0] val_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    valid_in,
    input  logic                    blank_lz_in,
    input  logic [3:0]              dim_in,
    output logic [6:0]              cat_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    pending_out,
    output logic                    frame_out
);

    localparam int DIV_W = $clog2(COUNT_PERIOD);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int ON_W  = DIV_W + 5;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] f_hex_glyph(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    logic [DIV_W-1:0]        r_div;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_frame;
    logic [4*NUM_DIGITS-1:0] r_disp_val;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pending;
    logic [6:0]              r_cat;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;

    logic                    w_term;
    logic                    w_boundary;
    logic [ON_W-1:0]         w_on;
    logic                    w_lit;
    logic [NUM_DIGITS-1:0]   w_zero_from;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [3:0]              w_nib;
    logic                    w_dp_bit;
    logic                    w_lz;
    logic                    w_blank;

    assign w_term     = (r_div == DIV_LAST);
    assign w_boundary = w_term && (r_idx == IDX_LAST);

    // Brightness: the anode is on for the first (dim+1)/16 of each slot.
    assign w_on  = ((ON_W'(dim_in) + ON_W'(1)) * ON_W'(COUNT_PERIOD)) >> 4;
    assign w_lit = (ON_W'(r_div) < w_on);

    // Slot divider, digit index and the frame pulse that follows a boundary.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_div   <= '0;
            r_idx   <= '0;
            r_frame <= 1'b0;
        end else begin
            r_frame <= w_boundary;
            if (w_term) begin
                r_div <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    // Double buffer: valid_in loads pending; pending moves to display only
    // at a frame boundary, so a frame never shows a mix of old and new.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_disp_val <= '0;
            r_disp_dp  <= '0;
            r_pend_val <= '0;
            r_pend_dp  <= '0;
            r_pending  <= 1'b0;
        end else begin
            if (w_boundary && r_pending) begin
                r_disp_val <= r_pend_val;
                r_disp_dp  <= r_pend_dp;
            end
            if (valid_in) begin
                r_pend_val <= val_in;
                r_pend_dp  <= dp_in;
                r_pending  <= 1'b1;
            end else if (w_boundary) begin
                r_pending  <= 1'b0;
            end
        end
    end

    // A digit counts as a leading zero only if it and every digit above it
    // hold zero with no decimal point; a lit point above stops the blanking.
    always_comb begin
        logic v_acc;
        w_zero_from = '0;
        v_acc       = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            v_acc          = v_acc && (r_disp_val[i*4 +: 4] == 4'h0) && !r_disp_dp[i];
            w_zero_from[i] = v_acc;
        end
    end

    // Select the nibble, point and blanking flag of the digit being scanned.
    always_comb begin
        w_nib    = 4'h0;
        w_dp_bit = 1'b0;
        w_lz     = 1'b0;
        w_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib       = r_disp_val[i*4 +: 4];
                w_dp_bit    = r_disp_dp[i];
                w_lz        = w_zero_from[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    assign w_blank = blank_lz_in && (r_idx != '0) && w_lz;

    // Registered segment, point and anode drive for the current slot.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cat <= 7'h7F;
            r_dp  <= 1'b1;
            r_an  <= '1;
        end else if (w_blank) begin
            r_cat <= 7'h7F;
            r_dp  <= 1'b1;
            r_an  <= '1;
        end else begin
            r_cat <= f_hex_glyph(w_nib);
            r_dp  <= ~w_dp_bit;
            r_an  <= w_lit ? ~w_onehot : '1;
        end
    end

    assign cat_out     = r_cat;
    assign dp_out      = r_dp;
    assign an_out      = r_an;
    assign pending_out = r_pending;
    assign frame_out   = r_frame;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with 4 digits and 16-cycle slots.
module tb_seven_seg_scanner;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [15:0] val_in;
    logic [3:0]  dp_in;
    logic        valid_in;
    logic        blank_lz_in;
    logic [3:0]  dim_in;
    logic [6:0]  cat_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        pending_out;
    logic        frame_out;

    int n_cmp = 0;
    int n_bad = 0;
    int k     = 0;   // clock edges since reset release

    seven_seg_scanner #(.NUM_DIGITS(4), .COUNT_PERIOD(16)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .val_in     (val_in),
        .dp_in      (dp_in),
        .valid_in   (valid_in),
        .blank_lz_in(blank_lz_in),
        .dim_in     (dim_in),
        .cat_out    (cat_out),
        .dp_out     (dp_out),
        .an_out     (an_out),
        .pending_out(pending_out),
        .frame_out  (frame_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at k=%0d: got %h, expected %h", tag, k, got, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[n];
    endfunction

    // Advance n cycles; after edge k the outputs show slot (k-1)/16 at
    // divider (k-1)%16. v/d give the expected displayed word, bm the
    // digits expected to be blanked.
    task automatic run(input int n, input logic [15:0] v, input logic [3:0] d,
                       input logic [3:0] bm);
        int idx, dv, on_c;
        logic [3:0] e_an;
        logic [6:0] e_cat;
        logic       e_dp;
        for (int j = 0; j < n; j++) begin
            @(posedge clk_in);
            k++;
            @(negedge clk_in);
            idx  = ((k - 1) / 16) % 4;
            dv   = (k - 1) % 16;
            on_c = int'(dim_in) + 1;
            if (bm[idx]) begin
                e_an  = 4'hF;
                e_cat = 7'h7F;
                e_dp  = 1'b1;
            end else begin
                e_an  = (dv < on_c) ? ~(4'b0001 << idx) : 4'hF;
                e_cat = glyph(v[idx*4 +: 4]);
                e_dp  = ~d[idx];
            end
            chk("an", 32'(an_out), 32'(e_an));
            chk("cat", 32'(cat_out), 32'(e_cat));
            chk("dp", 32'(dp_out), 32'(e_dp));
            chk("frame", 32'(frame_out), 32'((k % 64) == 0));
        end
    endtask

    initial begin
        rst_in      = 1'b1;
        val_in      = 16'h0;
        dp_in       = 4'h0;
        valid_in    = 1'b0;
        blank_lz_in = 1'b0;
        dim_in      = 4'd15;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_an", 32'(an_out), 32'hF);
        chk("rst_cat", 32'(cat_out), 32'h7F);
        chk("rst_dp", 32'(dp_out), 32'h1);
        chk("rst_pend", 32'(pending_out), 32'h0);
        chk("rst_frame", 32'(frame_out), 32'h0);
        rst_in = 1'b0;
        k = 0;

        // Idle scan: 0000 at full brightness for two frames.
        run(128, 16'h0000, 4'h0, 4'h0);

        // Mid-frame update held until the boundary, then F,A,2,1.
        run(12, 16'h0000, 4'h0, 4'h0);
        val_in = 16'h12AF; valid_in = 1'b1;
        run(1, 16'h0000, 4'h0, 4'h0);
        valid_in = 1'b0;
        chk("pend_set", 32'(pending_out), 32'h1);
        run(50, 16'h0000, 4'h0, 4'h0);
        chk("pend_hold", 32'(pending_out), 32'h1);
        run(1, 16'h0000, 4'h0, 4'h0);
        chk("pend_clr", 32'(pending_out), 32'h0);
        run(64, 16'h12AF, 4'h0, 4'h0);

        // Last write wins; a write on the boundary waits a frame.
        run(4, 16'h12AF, 4'h0, 4'h0);
        val_in = 16'h1111; valid_in = 1'b1;
        run(1, 16'h12AF, 4'h0, 4'h0);
        valid_in = 1'b0;
        run(4, 16'h12AF, 4'h0, 4'h0);
        val_in = 16'h2222; valid_in = 1'b1;
        run(1, 16'h12AF, 4'h0, 4'h0);
        valid_in = 1'b0;
        run(53, 16'h12AF, 4'h0, 4'h0);
        val_in = 16'h3333; valid_in = 1'b1;
        run(1, 16'h12AF, 4'h0, 4'h0);
        valid_in = 1'b0;
        chk("pend_bnd", 32'(pending_out), 32'h1);
        run(64, 16'h2222, 4'h0, 4'h0);
        chk("pend_bnd_clr", 32'(pending_out), 32'h0);
        run(64, 16'h3333, 4'h0, 4'h0);

        // Leading-zero blanking without and with a high decimal point.
        blank_lz_in = 1'b1;
        val_in = 16'h0050; dp_in = 4'h0; valid_in = 1'b1;
        run(1, 16'h3333, 4'h0, 4'h0);
        valid_in = 1'b0;
        run(63, 16'h3333, 4'h0, 4'h0);
        run(64, 16'h0050, 4'h0, 4'b1100);
        dp_in = 4'b1000; valid_in = 1'b1;
        run(1, 16'h0050, 4'h0, 4'b1100);
        valid_in = 1'b0;
        run(63, 16'h0050, 4'h0, 4'b1100);
        run(64, 16'h0050, 4'b1000, 4'h0);
        blank_lz_in = 1'b0;

        // Dimming: 4, 1 and 16 lit cycles per slot.
        dim_in = 4'd3;
        run(64, 16'h0050, 4'b1000, 4'h0);
        dim_in = 4'd0;
        run(64, 16'h0050, 4'b1000, 4'h0);
        dim_in = 4'd15;
        run(64, 16'h0050, 4'b1000, 4'h0);

        // Reset mid-slot with pending data, valid_in asserted alongside.
        val_in = 16'hABCD; dp_in = 4'hF; valid_in = 1'b1;
        run(1, 16'h0050, 4'b1000, 4'h0);
        valid_in = 1'b0;
        run(5, 16'h0050, 4'b1000, 4'h0);
        chk("pend_pre_rst", 32'(pending_out), 32'h1);
        rst_in = 1'b1; val_in = 16'hFFFF; valid_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        chk("mrst_an", 32'(an_out), 32'hF);
        chk("mrst_cat", 32'(cat_out), 32'h7F);
        chk("mrst_dp", 32'(dp_out), 32'h1);
        chk("mrst_pend", 32'(pending_out), 32'h0);
        chk("mrst_frame", 32'(frame_out), 32'h0);
        rst_in = 1'b0; valid_in = 1'b0; dp_in = 4'h0;
        k = 0;
        run(128, 16'h0000, 4'h0, 4'h0);
        chk("post_rst_pend", 32'(pending_out), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 8, giving the number of multiplexed digits (1..16).
REQ-002 The block SHALL have parameter COUNT_PERIOD, default 100000, giving clock cycles per digit slot (>=16).
REQ-003 The block SHALL use one clock and a reset that is synchronous and active-high; ports clk_in and rst_in.
REQ-004 clk_in  input  1  system clock; all state updates on rising edge.
REQ-005 rst_in  input  1  synchronous active-high reset.
REQ-006 val_in  input  4*NUM_DIGITS  hex value; nibble i drives digit i, digit 0 rightmost.
REQ-007 dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-008 valid_in  input  1  one-cycle capture strobe for val_in/dp_in.
REQ-009 blank_lz_in  input  1  leading-zero blanking enable.
REQ-010 dim_in  input  4  brightness; 15 = full, 0 = 1/16 duty.
REQ-011 cat_out  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 dp_out  output  1  decimal point, active-low.
REQ-013 an_out  output  NUM_DIGITS  anodes, active-low, at most one low.
REQ-014 pending_out  output  1  high while a captured value awaits commit.
REQ-015 frame_out  output  1  one-cycle pulse at each frame boundary.

Function
REQ-016 Divider counts 0..COUNT_PERIOD-1 and wraps; at terminal count the digit index advances, wrapping NUM_DIGITS-1 -> 0.
REQ-017 Frame boundary = cycle where divider is terminal and index is NUM_DIGITS-1; frame_out SHALL be high exactly in the following cycle.
REQ-018 valid_in high SHALL load val_in/dp_in into a pending register and set pending_out next cycle; a later valid_in before commit overwrites pending (last wins).
REQ-019 At a frame boundary with pending set, pending contents SHALL copy into the display register and pending_out SHALL clear; display register never changes mid-frame (no tearing).
REQ-020 valid_in coincident with a frame boundary: commit uses pre-existing pending contents; new value loads pending, pending_out stays high. If pending was clear, new value only loads pending.
REQ-021 Decode: standard hex 0-F glyphs (0=7'b1000000, 1=7'b1111001, 8=7'b0000000, F=7'b0001110).
REQ-022 on_cycles = ((dim_in+1)*COUNT_PERIOD)>>4, computed at >= clog2(COUNT_PERIOD)+5 bits; anode for current index SHALL be low only while divider < on_cycles, otherwise all anodes high.
REQ-023 dim_in SHALL be sampled each cycle; changes take effect on the next comparison.
REQ-024 Leading-zero blanking: with blank_lz_in=1, digit i>0 SHALL be blanked (anode high, cat 7'h7F, dp high) when display nibbles i..NUM_DIGITS-1 are all zero and display dp bit i is 0; digit 0 never blanked.
REQ-025 All outputs SHALL be registered; cat_out/dp_out/an_out reflect the index/divider of the previous cycle (one-cycle latency).

Reset
REQ-026 With rst_in high at a clock edge: divider 0, index 0, display and pending registers 0, pending_out 0, frame_out 0, an_out all ones, cat_out 7'h7F, dp_out 1.
REQ-027 Reset mid-frame SHALL discard pending and displayed values; first cycle after release displays digit 0 as "0" (at dim_in=15: an_out[0]=0, cat_out=7'b1000000).
REQ-028 rst_in SHALL take priority over valid_in in the same cycle.

Verification (NUM_DIGITS=4, COUNT_PERIOD=16 unless noted)
REQ-029 Reset then idle, dim_in=15 -> an_out walks 1110,1101,1011,0111 every 16 cycles; frame_out pulses every 64 cycles; cat_out=7'b1000000 throughout.
REQ-030 valid_in with val_in=16'h12AF mid-frame -> pending_out=1 until boundary, old value kept until boundary, then digits show F,A,2,1 from digit 0; pending_out=0.
REQ-031 Two valid_in (16'h1111 then 16'h2222) in one frame -> only 16'h2222 ever displayed; valid_in on the boundary cycle -> committed value is the prior pending, pending_out stays 1.
REQ-032 dim_in=3 -> each anode low exactly 4 of 16 cycles per slot; dim_in=0 -> 1 cycle; dim_in=15 -> 16 cycles.
REQ-033 blank_lz_in=1, val_in=16'h0050, dp_in=0 -> digits 3 blank, 2 blank, 1 shows 5, 0 shows 0; dp_in=4'b1000 -> digit 3 shows "0." and digit 2 shows 0.
REQ-034 rst_in asserted mid-slot with pending set -> next cycle outputs match REQ-026, pending_out=0, and after release display shows 0000.
